// File: rtl/commit_unit_pkg.sv
// Shared constants for the commit unit: decoded instruction ids, widths and FSM state encoding.
package commit_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  // Decoded instruction ids; the branch ids must stay contiguous from BEQ to BGEU.
  localparam int unsigned ID_LUI   = 1;
  localparam int unsigned ID_AUIPC = 2;
  localparam int unsigned ID_JAL   = 3;
  localparam int unsigned ID_JALR  = 4;
  localparam int unsigned ID_BEQ   = 5;
  localparam int unsigned ID_BNE   = 6;
  localparam int unsigned ID_BLT   = 7;
  localparam int unsigned ID_BGE   = 8;
  localparam int unsigned ID_BLTU  = 9;
  localparam int unsigned ID_BGEU  = 10;
  localparam int unsigned ID_LW    = 13;
  localparam int unsigned ID_SB    = 16;
  localparam int unsigned ID_SH    = 17;
  localparam int unsigned ID_SW    = 18;
  localparam int unsigned ID_ADDI  = 19;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } state_e;

endpackage

// File: rtl/commit_decode.sv
// Combinational classification of a decoded instruction id into store / branch / register write.
module commit_decode
  import commit_unit_pkg::*;
#(
  parameter int ID_W = 6
) (
  input  logic [ID_W-1:0] instr_id_in,
  output logic            is_store_out,
  output logic            is_branch_out,
  output logic            writes_rd_out
);

  always_comb begin
    is_store_out  = (instr_id_in == ID_W'(ID_SB)) || (instr_id_in == ID_W'(ID_SH)) ||
                    (instr_id_in == ID_W'(ID_SW));
    is_branch_out = (instr_id_in >= ID_W'(ID_BEQ)) && (instr_id_in <= ID_W'(ID_BGEU));
    writes_rd_out = !is_store_out && !is_branch_out;
  end

endmodule

// File: rtl/commit_unit.sv
// ROB-head commit unit: register write-back, store release to the LSB, branch flush/redirect.
// Optional feature macro: COMMIT_CNT_EN adds commit_cnt_out, a count of accepted bundles.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int ROB_IDX_W = 4,
  parameter int LSB_IDX_W = 4,
  parameter int ID_W      = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 commit_en_in,
  input  logic [ID_W-1:0]      instr_id_in,
  input  logic [REG_IDX_W-1:0] rd_in,
  input  logic [ROB_IDX_W-1:0] rob_pos_in,
  input  logic [LSB_IDX_W-1:0] lsb_pos_in,
  input  logic [XLEN-1:0]      res_in,
  input  logic                 jump_en_in,
  input  logic [XLEN-1:0]      jump_a_in,
  output logic                 commit_ready_out,
  output logic                 rf_we_out,
  output logic [REG_IDX_W-1:0] rf_rd_out,
  output logic [XLEN-1:0]      rf_data_out,
  output logic [ROB_IDX_W-1:0] rf_rob_pos_out,
  output logic                 lsb_commit_en_out,
  output logic [LSB_IDX_W-1:0] lsb_commit_pos_out,
  input  logic                 lsb_store_done_in,
  output logic                 clear_branch_out,
  output logic                 pc_redirect_en_out,
  output logic [XLEN-1:0]      pc_redirect_a_out,
`ifdef COMMIT_CNT_EN
  output logic [XLEN-1:0]      commit_cnt_out,
`endif
  output state_e               state_dbg_out
);

  // Handshake: a bundle transfers on a rising edge where commit_en_in, rdy_in and
  // the internal ready (state == IDLE) are all high; otherwise it is dropped, not queued.

  state_e                 state_q, state_d;
  logic                   is_store, is_branch, writes_rd, accept;
  logic                   rf_we_q, rf_we_d;
  logic [REG_IDX_W-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]        rf_data_q, rf_data_d;
  logic [ROB_IDX_W-1:0]   rf_rob_q, rf_rob_d;
  logic                   lsb_en_q, lsb_en_d;
  logic [LSB_IDX_W-1:0]   lsb_pos_q, lsb_pos_d;
  logic                   clear_q, clear_d;
  logic [XLEN-1:0]        redir_a_q, redir_a_d;

  commit_decode #(.ID_W(ID_W)) u_decode (
    .instr_id_in   (instr_id_in),
    .is_store_out  (is_store),
    .is_branch_out (is_branch),
    .writes_rd_out (writes_rd)
  );

  assign accept = commit_en_in && rdy_in && (state_q == ST_IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A jump wins over a store so a mispredicted bundle never releases memory.
  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          if (commit_en_in) begin
            if (jump_en_in)    state_d = ST_FLUSH;
            else if (is_store) state_d = ST_STORE_WAIT;
          end
        end
        ST_STORE_WAIT: if (lsb_store_done_in) state_d = ST_IDLE;
        ST_FLUSH:      state_d = ST_IDLE;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    rf_rob_d  = rf_rob_q;
    lsb_en_d  = 1'b0;
    lsb_pos_d = lsb_pos_q;
    clear_d   = 1'b0;
    redir_a_d = redir_a_q;
    if (accept) begin
      if (writes_rd && (rd_in != '0)) begin
        rf_we_d   = 1'b1;
        rf_rd_d   = rd_in;
        rf_data_d = res_in;
        rf_rob_d  = rob_pos_in;
      end
      if (is_store && !jump_en_in) begin
        lsb_en_d  = 1'b1;
        lsb_pos_d = lsb_pos_in;
      end
      if (jump_en_in) begin
        clear_d   = 1'b1;
        redir_a_d = jump_a_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      rf_rob_q  <= '0;
      lsb_en_q  <= 1'b0;
      lsb_pos_q <= '0;
      clear_q   <= 1'b0;
      redir_a_q <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      rf_rob_q  <= rf_rob_d;
      lsb_en_q  <= lsb_en_d;
      lsb_pos_q <= lsb_pos_d;
      clear_q   <= clear_d;
      redir_a_q <= redir_a_d;
    end
  end

  // Pulses are masked by rdy_in so a frozen cycle never presents an enable.
  assign commit_ready_out   = rst_in && (state_q == ST_IDLE);
  assign rf_we_out          = rf_we_q && rdy_in;
  assign rf_rd_out          = rf_rd_q;
  assign rf_data_out        = rf_data_q;
  assign rf_rob_pos_out     = rf_rob_q;
  assign lsb_commit_en_out  = lsb_en_q && rdy_in;
  assign lsb_commit_pos_out = lsb_pos_q;
  assign clear_branch_out   = clear_q && rdy_in;
  assign pc_redirect_en_out = clear_q && rdy_in;
  assign pc_redirect_a_out  = redir_a_q;
  assign state_dbg_out      = state_q;

`ifdef COMMIT_CNT_EN
  logic [XLEN-1:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + XLEN'(accept);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign commit_cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed self-checking bench for commit_unit (optionally built with COMMIT_CNT_EN).
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        commit_en_in;
  logic [5:0]  instr_id_in;
  logic [4:0]  rd_in;
  logic [3:0]  rob_pos_in;
  logic [3:0]  lsb_pos_in;
  logic [31:0] res_in;
  logic        jump_en_in;
  logic [31:0] jump_a_in;
  logic        commit_ready_out;
  logic        rf_we_out;
  logic [4:0]  rf_rd_out;
  logic [31:0] rf_data_out;
  logic [3:0]  rf_rob_pos_out;
  logic        lsb_commit_en_out;
  logic [3:0]  lsb_commit_pos_out;
  logic        lsb_store_done_in;
  logic        clear_branch_out;
  logic        pc_redirect_en_out;
  logic [31:0] pc_redirect_a_out;
`ifdef COMMIT_CNT_EN
  logic [31:0] commit_cnt_out;
`endif
  state_e      state_dbg_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  commit_unit dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .commit_en_in       (commit_en_in),
    .instr_id_in        (instr_id_in),
    .rd_in              (rd_in),
    .rob_pos_in         (rob_pos_in),
    .lsb_pos_in         (lsb_pos_in),
    .res_in             (res_in),
    .jump_en_in         (jump_en_in),
    .jump_a_in          (jump_a_in),
    .commit_ready_out   (commit_ready_out),
    .rf_we_out          (rf_we_out),
    .rf_rd_out          (rf_rd_out),
    .rf_data_out        (rf_data_out),
    .rf_rob_pos_out     (rf_rob_pos_out),
    .lsb_commit_en_out  (lsb_commit_en_out),
    .lsb_commit_pos_out (lsb_commit_pos_out),
    .lsb_store_done_in  (lsb_store_done_in),
    .clear_branch_out   (clear_branch_out),
    .pc_redirect_en_out (pc_redirect_en_out),
    .pc_redirect_a_out  (pc_redirect_a_out),
`ifdef COMMIT_CNT_EN
    .commit_cnt_out     (commit_cnt_out),
`endif
    .state_dbg_out      (state_dbg_out)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  // Driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_bundle(input int unsigned id, input logic [4:0] rd,
                              input logic [3:0] rob, input logic [3:0] lsb,
                              input logic [31:0] res, input logic jen,
                              input logic [31:0] ja);
    commit_en_in = 1'b1;
    instr_id_in  = 6'(id);
    rd_in        = rd;
    rob_pos_in   = rob;
    lsb_pos_in   = lsb;
    res_in       = res;
    jump_en_in   = jen;
    jump_a_in    = ja;
  endtask

  task automatic idle_bundle();
    commit_en_in = 1'b0;
    instr_id_in  = '0;
    rd_in        = '0;
    rob_pos_in   = '0;
    lsb_pos_in   = '0;
    res_in       = '0;
    jump_en_in   = 1'b0;
    jump_a_in    = '0;
  endtask

  task automatic apply_reset();
    rst_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rdy_in = 1'b1;
    lsb_store_done_in = 1'b0;
    idle_bundle();
    rst_in = 1'b0;
    tick();
    checks++; if (commit_ready_out !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset: got %0b exp 0", commit_ready_out); end
    checks++; if (rf_we_out !== 1'b0 || lsb_commit_en_out !== 1'b0 || clear_branch_out !== 1'b0 || pc_redirect_en_out !== 1'b0) begin
      errors++; $display("FAIL rst_enables: got we=%0b lsb=%0b clr=%0b redir=%0b exp all 0", rf_we_out, lsb_commit_en_out, clear_branch_out, pc_redirect_en_out);
    end
    checks++; if (rf_data_out !== 32'h0 || pc_redirect_a_out !== 32'h0 || rf_rd_out !== 5'h0) begin
      errors++; $display("FAIL rst_data: got data=%h a=%h rd=%0d exp 0", rf_data_out, pc_redirect_a_out, rf_rd_out);
    end
    rst_in = 1'b1;
    #1;
    checks++; if (commit_ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0b exp 1", commit_ready_out); end
    checks++; if (state_dbg_out !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d exp %0d", state_dbg_out, ST_IDLE); end
    tick();
  endtask

  task automatic test_write();
    drive_bundle(ID_ADDI, 5'd5, 4'd3, 4'd0, 32'h0000_002A, 1'b0, 32'h0);
    tick();
    idle_bundle();
    checks++; if (rf_we_out !== 1'b1) begin errors++; $display("FAIL wr_we: got %0b exp 1", rf_we_out); end
    checks++; if (rf_rd_out !== 5'd5 || rf_data_out !== 32'h2A || rf_rob_pos_out !== 4'd3) begin
      errors++; $display("FAIL wr_fields: got rd=%0d data=%h rob=%0d exp rd=5 data=2a rob=3", rf_rd_out, rf_data_out, rf_rob_pos_out);
    end
    checks++; if (commit_ready_out !== 1'b1) begin errors++; $display("FAIL wr_ready: got %0b exp 1", commit_ready_out); end
    checks++; if (lsb_commit_en_out !== 1'b0 || clear_branch_out !== 1'b0) begin
      errors++; $display("FAIL wr_side_pulses: got lsb=%0b clr=%0b exp 0 0", lsb_commit_en_out, clear_branch_out);
    end
    tick();
    checks++; if (rf_we_out !== 1'b0) begin errors++; $display("FAIL wr_one_cycle: got %0b exp 0", rf_we_out); end
  endtask

  task automatic test_store();
    drive_bundle(ID_SW, 5'd4, 4'd1, 4'd7, 32'h1234, 1'b0, 32'h0);
    tick();
    idle_bundle();
    checks++; if (lsb_commit_en_out !== 1'b1 || lsb_commit_pos_out !== 4'd7) begin
      errors++; $display("FAIL st_pulse: got en=%0b pos=%0d exp 1 7", lsb_commit_en_out, lsb_commit_pos_out);
    end
    checks++; if (commit_ready_out !== 1'b0 || state_dbg_out !== ST_STORE_WAIT) begin
      errors++; $display("FAIL st_c1_state: got ready=%0b st=%0d exp 0 %0d", commit_ready_out, state_dbg_out, ST_STORE_WAIT);
    end
    checks++; if (rf_we_out !== 1'b0) begin errors++; $display("FAIL st_no_rf: got %0b exp 0", rf_we_out); end
    // a bundle offered while not ready must be dropped
    drive_bundle(ID_ADDI, 5'd9, 4'd2, 4'd0, 32'h99, 1'b0, 32'h0);
    tick();
    idle_bundle();
    checks++; if (lsb_commit_en_out !== 1'b0 || commit_ready_out !== 1'b0) begin
      errors++; $display("FAIL st_c2: got lsb=%0b ready=%0b exp 0 0", lsb_commit_en_out, commit_ready_out);
    end
    tick();
    checks++; if (rf_we_out !== 1'b0 || commit_ready_out !== 1'b0) begin
      errors++; $display("FAIL st_c3_ignored: got we=%0b ready=%0b exp 0 0", rf_we_out, commit_ready_out);
    end
    tick();
    checks++; if (commit_ready_out !== 1'b0) begin errors++; $display("FAIL st_c4_ready: got %0b exp 0", commit_ready_out); end
    lsb_store_done_in = 1'b1;
    tick();
    lsb_store_done_in = 1'b0;
    checks++; if (commit_ready_out !== 1'b1 || state_dbg_out !== ST_IDLE) begin
      errors++; $display("FAIL st_release: got ready=%0b st=%0d exp 1 %0d", commit_ready_out, state_dbg_out, ST_IDLE);
    end
  endtask

  task automatic test_branch();
    drive_bundle(ID_BEQ, 5'd3, 4'd4, 4'd0, 32'h0, 1'b1, 32'h0000_1000);
    tick();
    idle_bundle();
    checks++; if (clear_branch_out !== 1'b1 || pc_redirect_en_out !== 1'b1 || pc_redirect_a_out !== 32'h1000) begin
      errors++; $display("FAIL br_pulse: got clr=%0b en=%0b a=%h exp 1 1 00001000", clear_branch_out, pc_redirect_en_out, pc_redirect_a_out);
    end
    checks++; if (commit_ready_out !== 1'b0 || rf_we_out !== 1'b0) begin
      errors++; $display("FAIL br_flush: got ready=%0b we=%0b exp 0 0", commit_ready_out, rf_we_out);
    end
    tick();
    checks++; if (clear_branch_out !== 1'b0 || pc_redirect_en_out !== 1'b0 || commit_ready_out !== 1'b1) begin
      errors++; $display("FAIL br_after: got clr=%0b en=%0b ready=%0b exp 0 0 1", clear_branch_out, pc_redirect_en_out, commit_ready_out);
    end
  endtask

  task automatic test_jal_link();
    drive_bundle(ID_JAL, 5'd1, 4'd6, 4'd0, 32'h0000_0104, 1'b1, 32'h0000_0200);
    tick();
    idle_bundle();
    checks++; if (rf_we_out !== 1'b1 || rf_rd_out !== 5'd1 || rf_data_out !== 32'h104) begin
      errors++; $display("FAIL jal_link: got we=%0b rd=%0d data=%h exp 1 1 00000104", rf_we_out, rf_rd_out, rf_data_out);
    end
    checks++; if (clear_branch_out !== 1'b1 || pc_redirect_a_out !== 32'h200) begin
      errors++; $display("FAIL jal_redirect: got clr=%0b a=%h exp 1 00000200", clear_branch_out, pc_redirect_a_out);
    end
    tick();
    checks++; if (rf_we_out !== 1'b0 || clear_branch_out !== 1'b0) begin
      errors++; $display("FAIL jal_after: got we=%0b clr=%0b exp 0 0", rf_we_out, clear_branch_out);
    end
  endtask

  task automatic test_rd_zero();
    drive_bundle(ID_ADDI, 5'd0, 4'd2, 4'd0, 32'hDEAD_BEEF, 1'b0, 32'h0);
    tick();
    idle_bundle();
    checks++; if (rf_we_out !== 1'b0) begin errors++; $display("FAIL rd0_no_write: got %0b exp 0", rf_we_out); end
    checks++; if (commit_ready_out !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %0b exp 1", commit_ready_out); end
  endtask

  task automatic test_reset_in_store_wait();
    drive_bundle(ID_SW, 5'd0, 4'd0, 4'd5, 32'h0, 1'b0, 32'h0);
    tick();
    idle_bundle();
    checks++; if (lsb_commit_en_out !== 1'b1 || lsb_commit_pos_out !== 4'd5) begin
      errors++; $display("FAIL rsw_pulse: got en=%0b pos=%0d exp 1 5", lsb_commit_en_out, lsb_commit_pos_out);
    end
    tick();
    rst_in = 1'b0;
    #1;
    checks++; if (state_dbg_out !== ST_IDLE || lsb_commit_pos_out !== 4'd0) begin
      errors++; $display("FAIL rsw_async: got st=%0d pos=%0d exp %0d 0", state_dbg_out, lsb_commit_pos_out, ST_IDLE);
    end
    tick();
    tick();
    rst_in = 1'b1;
    #1;
    checks++; if (commit_ready_out !== 1'b1) begin errors++; $display("FAIL rsw_ready: got %0b exp 1", commit_ready_out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (lsb_commit_en_out !== 1'b0 || commit_ready_out !== 1'b1) begin
        errors++; $display("FAIL rsw_no_pulse: cycle %0d got lsb=%0b ready=%0b exp 0 1", i, lsb_commit_en_out, commit_ready_out);
      end
    end
  endtask

  task automatic test_back_to_back_freeze();
    logic [31:0] exp_data;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      drive_bundle(ID_ADDI, 5'(i), 4'(i), 4'd0, 32'(100 + i), 1'b0, 32'h0);
      exp_q.push_back(32'(100 + i));
      tick();
      exp_data = exp_q.pop_front();
      checks++; if (rf_we_out !== 1'b1 || rf_rd_out !== 5'(i) || rf_data_out !== exp_data) begin
        errors++; $display("FAIL b2b_%0d: got we=%0b rd=%0d data=%h exp 1 %0d %h", i, rf_we_out, rf_rd_out, rf_data_out, i, exp_data);
      end
    end
    rdy_in = 1'b0;
    drive_bundle(ID_ADDI, 5'd7, 4'd7, 4'd0, 32'h777, 1'b0, 32'h0);
    #1;
    checks++; if (rf_we_out !== 1'b0) begin errors++; $display("FAIL frz_mask: got %0b exp 0", rf_we_out); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (rf_we_out !== 1'b0 || lsb_commit_en_out !== 1'b0 || clear_branch_out !== 1'b0 || pc_redirect_en_out !== 1'b0) begin
        errors++; $display("FAIL frz_pulses_%0d: got we=%0b lsb=%0b clr=%0b red=%0b exp 0", i, rf_we_out, lsb_commit_en_out, clear_branch_out, pc_redirect_en_out);
      end
      checks++; if (rf_rd_out !== 5'd5 || rf_data_out !== 32'd105) begin
        errors++; $display("FAIL frz_hold_%0d: got rd=%0d data=%h exp 5 00000069", i, rf_rd_out, rf_data_out);
      end
`ifdef COMMIT_CNT_EN
      checks++; if (commit_cnt_out !== 32'd5) begin errors++; $display("FAIL frz_cnt_%0d: got %0d exp 5", i, commit_cnt_out); end
`endif
    end
    rdy_in = 1'b1;
    idle_bundle();
    tick();
    checks++; if (rf_we_out !== 1'b0 || rf_data_out !== 32'd105) begin
      errors++; $display("FAIL frz_dropped: got we=%0b data=%h exp 0 00000069", rf_we_out, rf_data_out);
    end
`ifdef COMMIT_CNT_EN
    checks++; if (commit_cnt_out !== 32'd5) begin errors++; $display("FAIL cnt_final: got %0d exp 5", commit_cnt_out); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_store();
    test_branch();
    test_jal_link();
    test_rd_zero();
    test_reset_in_store_wait();
    test_back_to_back_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
